// File: rtl/arriskv_pkg.sv
// Shared types and constants for the arriskv front end.
package arriskv_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_fifo.sv
// Synchronous FIFO with flush; power-of-two depth, occupancy count.
module fetch_fifo #(
    parameter int depth_p = 2,
    parameter int width_p = 64,
    localparam int aw_c = $clog2(depth_p)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_flush,
    input  logic               i_push,
    input  logic [width_p-1:0] i_data,
    input  logic               i_pop,
    output logic [width_p-1:0] o_data,
    output logic [aw_c:0]      o_count,
    output logic               o_full,
    output logic               o_empty
);

    logic [width_p-1:0] mem_q [depth_p];
    logic [aw_c-1:0]    rd_ptr_q, rd_ptr_d;
    logic [aw_c-1:0]    wr_ptr_q, wr_ptr_d;
    logic [aw_c:0]      count_q, count_d;
    logic               do_push, do_pop;

    assign o_empty = (count_q == '0);
    assign o_full  = (count_q == (aw_c+1)'(depth_p));
    assign o_count = count_q;
    assign o_data  = mem_q[rd_ptr_q];

    always_comb begin
        do_pop   = i_pop && !o_empty;
        do_push  = i_push && (!o_full || do_pop);
        rd_ptr_d = rd_ptr_q + aw_c'(do_pop);
        wr_ptr_d = wr_ptr_q + aw_c'(do_push);
        count_d  = count_q + (aw_c+1)'(do_push) - (aw_c+1)'(do_pop);
        if (i_flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: only entries counted by count_q are ever read.
    always_ff @(posedge clk) begin
        if (do_push && !i_flush) begin
            mem_q[wr_ptr_q] <= i_data;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: PC generation, imem requests, prefetch FIFO, redirect flush.
module instr_fetch
    import arriskv_pkg::*;
#(
    parameter int                 wd_instr_p   = 32,
    parameter int                 wd_pc_p      = 32,
    parameter logic [wd_pc_p-1:0] reset_pc_p   = '0,
    parameter int                 fifo_depth_p = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  o_imem_req,
    output logic [wd_pc_p-1:0]    o_imem_addr,
    input  logic                  i_imem_gnt,
    input  logic                  i_imem_rvalid,
    input  logic [wd_instr_p-1:0] i_imem_rdata,
    input  logic                  i_redirect,
    input  logic [wd_pc_p-1:0]    i_redirect_pc,
    output logic [wd_instr_p-1:0] o_instr,
    output logic [wd_pc_p-1:0]    o_instr_pc,
    output logic                  o_instr_valid,
    input  logic                  i_instr_ready
);

    localparam int max_outst_p = fifo_depth_p;
    localparam int cw_c        = $clog2(fifo_depth_p) + 1;
    localparam int ew_c        = wd_instr_p + wd_pc_p;

    fetch_state_t         state_q, state_d;
    logic [wd_pc_p-1:0]   fetch_pc_q, fetch_pc_d;
    logic [wd_pc_p-1:0]   rsp_pc_q, rsp_pc_d;
    logic [cw_c-1:0]      outst_q, outst_d;
    logic [cw_c-1:0]      discard_q, discard_d;
    logic [cw_c:0]        used;
    logic                 gnt_fire, rsp_keep, rsp_drop;
    logic                 fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [ew_c-1:0]      fifo_wdata, fifo_rdata;
    logic [cw_c-1:0]      fifo_count;
    logic [wd_pc_p-1:0]   redirect_pc;

    assign redirect_pc = i_redirect_pc & ~wd_pc_p'(3);
    assign fifo_wdata  = {i_imem_rdata, rsp_pc_q};

    fetch_fifo #(
        .depth_p (fifo_depth_p),
        .width_p (ew_c)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_flush (i_redirect),
        .i_push  (fifo_push),
        .i_data  (fifo_wdata),
        .i_pop   (fifo_pop),
        .o_data  (fifo_rdata),
        .o_count (fifo_count),
        .o_full  (fifo_full),
        .o_empty (fifo_empty)
    );

    assign o_instr_valid = !fifo_empty;
    assign o_instr       = o_instr_valid ? fifo_rdata[ew_c-1:wd_pc_p]
                                         : wd_instr_p'(NOP_INSTR);
    assign o_instr_pc    = o_instr_valid ? fifo_rdata[wd_pc_p-1:0] : '0;
    assign o_imem_addr   = fetch_pc_q;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        discard_d  = discard_q;
        fifo_pop   = o_instr_valid && i_instr_ready;
        // A slot freed by this cycle's pop is credited so decode sees 1/cycle.
        used       = (cw_c+1)'(outst_q) + (cw_c+1)'(fifo_count)
                   - (cw_c+1)'(fifo_pop);
        o_imem_req = (state_q != IDLE) && !i_redirect
                   && (used < (cw_c+1)'(max_outst_p));
        gnt_fire   = o_imem_req && i_imem_gnt;
        rsp_drop   = i_imem_rvalid && ((discard_q != '0) || i_redirect);
        rsp_keep   = i_imem_rvalid && !rsp_drop;
        fifo_push  = rsp_keep;
        outst_d    = outst_q + cw_c'(gnt_fire) - cw_c'(i_imem_rvalid);
        if (gnt_fire) begin
            fetch_pc_d = fetch_pc_q + wd_pc_p'(4);
        end
        if (rsp_keep) begin
            rsp_pc_d = rsp_pc_q + wd_pc_p'(4);
        end
        if (i_imem_rvalid && (discard_q != '0)) begin
            discard_d = discard_q - 1'b1;
        end
        unique case (state_q)
            IDLE:    state_d = FETCH;
            FETCH:   state_d = FETCH;
            DRAIN:   if (discard_d == '0) state_d = FETCH;
            default: state_d = IDLE;
        endcase
        if (i_redirect) begin
            fetch_pc_d = redirect_pc;
            rsp_pc_d   = redirect_pc;
            discard_d  = outst_d;
            state_d    = (outst_d != '0) ? DRAIN : FETCH;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            fetch_pc_q <= reset_pc_p;
            rsp_pc_q   <= reset_pc_p;
            outst_q    <= '0;
            discard_q  <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            outst_q    <= outst_d;
            discard_q  <= discard_d;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(fifo_push && fifo_full && !fifo_pop));

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch with an in-order latency memory model.
module tb_instr_fetch;
    import arriskv_pkg::*;

    localparam logic [31:0] K = 32'hC0DE_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, req, gnt, rvalid, redir, ready, valid;
    logic [31:0] addr, rdata, rpc, instr, ipc;

    logic        w_req, w_valid;
    logic        w_rvalid = 1'b0;
    logic [31:0] w_addr, w_instr, w_pc;
    logic [31:0] w_rdata = '0;

    int n_cmp = 0;
    int n_fail = 0;

    function automatic void check(string name, logic [31:0] act,
                                  logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    instr_fetch u_dut (
        .clk           (clk),
        .rst           (rst),
        .o_imem_req    (req),
        .o_imem_addr   (addr),
        .i_imem_gnt    (gnt),
        .i_imem_rvalid (rvalid),
        .i_imem_rdata  (rdata),
        .i_redirect    (redir),
        .i_redirect_pc (rpc),
        .o_instr       (instr),
        .o_instr_pc    (ipc),
        .o_instr_valid (valid),
        .i_instr_ready (ready)
    );

    instr_fetch #(.reset_pc_p(32'hFFFF_FFF8)) u_wrap (
        .clk           (clk),
        .rst           (rst),
        .o_imem_req    (w_req),
        .o_imem_addr   (w_addr),
        .i_imem_gnt    (1'b1),
        .i_imem_rvalid (w_rvalid),
        .i_imem_rdata  (w_rdata),
        .i_redirect    (1'b0),
        .i_redirect_pc (32'h0),
        .o_instr       (w_instr),
        .o_instr_pc    (w_pc),
        .o_instr_valid (w_valid),
        .i_instr_ready (1'b1)
    );

    // In-order memory: response presented lat cycles after the grant edge.
    typedef struct {
        logic [31:0] a;
        int          due;
    } pend_t;
    pend_t pend[$];
    int    cyc = 0;
    int    lat = 1;

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            pend.delete();
            #1;
            rvalid = 1'b0;
            rdata  = '0;
        end else begin
            if (req && gnt) pend.push_back('{addr, cyc + lat - 1});
            #1;
            if (pend.size() != 0 && pend[0].due <= cyc) begin
                rvalid = 1'b1;
                rdata  = pend[0].a ^ K;
                void'(pend.pop_front());
            end else begin
                rvalid = 1'b0;
            end
        end
    end

    // Scoreboard: grants push expected PCs, decode transfers pop them.
    logic [31:0] exp_q[$];
    logic [31:0] exp_addr = '0;
    logic        cap_gnt = 1'b0;
    logic        cap_pop = 1'b0;
    logic [31:0] post_addr = '0;
    logic [31:0] post_pc = '0;
    logic [31:0] post_instr = '0;

    always @(posedge clk) begin
        logic [31:0] e;
        if (rst) begin
            exp_q.delete();
            exp_addr = '0;
            cap_gnt  = 1'b1;
            cap_pop  = 1'b1;
        end else begin
            if (!valid) begin
                check("idle_instr", instr, NOP_INSTR);
                check("idle_pc", ipc, 32'h0);
            end
            if (valid && ready) begin
                check("sb_nonempty", 32'(exp_q.size() > 0), 32'h1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("out_pc", ipc, e);
                    check("out_instr", instr, e ^ K);
                end
                if (cap_pop) begin
                    post_pc    = ipc;
                    post_instr = instr;
                    cap_pop    = 1'b0;
                end
            end
            if (req && gnt) begin
                check("req_addr", addr, exp_addr);
                exp_q.push_back(exp_addr);
                exp_addr += 32'h4;
                if (cap_gnt) begin
                    post_addr = addr;
                    cap_gnt   = 1'b0;
                end
            end
            if (redir) begin
                exp_q.delete();
                exp_addr = rpc & ~32'h3;
                cap_gnt  = 1'b1;
                cap_pop  = 1'b1;
            end
        end
    end

    // Wrap instance: zero-wait memory, record the first three addresses.
    int          wn = 0;
    logic [31:0] waddr [3];
    logic [31:0] wfirst_pc = '0;
    logic        wgot = 1'b0;

    always @(posedge clk) begin
        logic [31:0] a;
        logic        f;
        f = !rst && w_req;
        a = w_addr;
        if (f && wn < 3) begin
            waddr[wn] = a;
            wn++;
        end
        if (!rst && w_valid && !wgot) begin
            wfirst_pc = w_pc;
            wgot      = 1'b1;
        end
        #1;
        w_rvalid = f;
        w_rdata  = a;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int nv;
        int t;
        logic [31:0] a0;
        rst = 1'b1; gnt = 1'b0; ready = 1'b0; redir = 1'b0; rpc = '0;
        repeat (3) @(negedge clk);
        check("rst_req", 32'(req), 32'h0);
        check("rst_addr", addr, 32'h0);
        check("rst_instr", instr, NOP_INSTR);
        check("rst_pc", ipc, 32'h0);
        check("rst_valid", 32'(valid), 32'h0);

        rst = 1'b0; gnt = 1'b1; ready = 1'b1;
        @(negedge clk);
        check("c1_req", 32'(req), 32'h1);
        check("c1_addr", addr, 32'h0);
        check("c1_valid", 32'(valid), 32'h0);
        @(negedge clk);
        check("c2_valid", 32'(valid), 32'h0);
        @(negedge clk);
        check("c3_valid", 32'(valid), 32'h1);
        check("c3_pc", ipc, 32'h0);
        check("c3_instr", instr, 32'hC0DE_0000);
        nv = 0;
        repeat (20) begin
            @(negedge clk);
            if (valid) nv++;
        end
        check("throughput", 32'(nv), 32'd20);

        ready = 1'b0;
        repeat (10) @(negedge clk);
        check("stall_req", 32'(req), 32'h0);
        check("stall_backlog", 32'(exp_q.size()), 32'd2);
        check("stall_valid", 32'(valid), 32'h1);
        ready = 1'b1;
        repeat (6) @(negedge clk);

        gnt = 1'b0;
        @(negedge clk);
        a0 = addr;
        repeat (5) begin
            @(negedge clk);
            check("nognt_req", 32'(req), 32'h1);
            check("nognt_addr", addr, a0);
        end

        lat = 3; gnt = 1'b1;
        t = 0;
        while (pend.size() != 2 && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("two_outstanding", 32'(pend.size()), 32'd2);
        redir = 1'b1; rpc = 32'h0000_0103;
        #1;
        check("redir_req", 32'(req), 32'h0);
        @(negedge clk);
        redir = 1'b0;
        t = 0;
        while ((cap_pop || cap_gnt) && t < 40) begin
            @(negedge clk);
            t++;
        end
        check("redir_done", 32'(cap_pop || cap_gnt), 32'h0);
        check("redir_addr", post_addr, 32'h0000_0100);
        check("redir_pc", post_pc, 32'h0000_0100);
        check("redir_instr", post_instr, 32'hC0DE_0100);

        lat = 1; ready = 1'b0;
        repeat (6) @(negedge clk);
        check("full_backlog", 32'(exp_q.size()), 32'd2);
        check("full_valid", 32'(valid), 32'h1);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 32'(valid), 32'h0);
        check("mid_rst_req", 32'(req), 32'h0);
        check("mid_rst_instr", instr, NOP_INSTR);
        check("mid_rst_addr", addr, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0; ready = 1'b1;
        t = 0;
        while ((cap_pop || cap_gnt) && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("rst_restart_addr", post_addr, 32'h0);
        check("rst_restart_pc", post_pc, 32'h0);

        repeat (8) @(negedge clk);
        gnt = 1'b0;
        repeat (8) @(negedge clk);
        check("all_delivered", 32'(exp_q.size()), 32'd0);
        check("mem_idle", 32'(pend.size()), 32'd0);

        check("wrap_n", 32'(wn), 32'd3);
        check("wrap_a0", waddr[0], 32'hFFFF_FFF8);
        check("wrap_a1", waddr[1], 32'hFFFF_FFFC);
        check("wrap_a2", waddr[2], 32'h0000_0000);
        check("wrap_pc", wfirst_pc, 32'hFFFF_FFF8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
